// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames (8E1 when UART_TX_PARITY_EN is defined), LSB first,
// with a one-byte holding register so back-to-back frames leave no idle gap.
module uart_tx #(
  parameter int UART_BPS = 9600,
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx
);

  localparam int          BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam logic [15:0] BAUD_LAST    = 16'(BAUD_CNT_MAX - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic        hold_valid_q, hold_valid_d;
  logic        tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  logic bit_done;
  logic accept;
  logic load;

  assign bit_done = (state_q != IDLE) && (baud_cnt_q == BAUD_LAST);
  assign accept   = pi_flag && !hold_valid_q;
  // A held byte starts a frame from IDLE, or straight after the last stop-bit clock.
  assign load     = hold_valid_q && ((state_q == IDLE) || ((state_q == STOP) && bit_done));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed by the combinational processes.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      baud_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      tx_q         <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      tx_q         <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case statements can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (hold_valid_q) state_d = START;
      START: if (bit_done) state_d = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (bit_done && bit_idx_q == 3'd7) state_d = PARITY;
      PARITY: if (bit_done) state_d = STOP;
`else
      DATA:   if (bit_done && bit_idx_q == 3'd7) state_d = STOP;
`endif
      STOP:  if (bit_done) state_d = hold_valid_q ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    baud_cnt_d   = (state_q == IDLE || bit_done) ? 16'd0 : baud_cnt_q + 16'd1;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    tx_d         = tx_q;
`ifdef UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif

    if (accept) begin
      hold_data_d  = pi_data;
      hold_valid_d = 1'b1;
    end

    if (load) begin
      shift_d      = hold_data_q;
      hold_valid_d = 1'b0;
      bit_idx_d    = 3'd0;
      tx_d         = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d     = ^hold_data_q;
`endif
    end else if (bit_done) begin
      unique case (state_q)
        START: tx_d = shift_q[0];
        DATA: begin
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            tx_d      = parity_q;
`else
            tx_d      = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
        default: tx_d = 1'b1;
      endcase
    end
  end

  always_comb begin
    tx       = tx_q;
    tx_ready = !hold_valid_q;
    tx_busy  = (state_q != IDLE) || hold_valid_q;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 16 clocks per bit: a queue of accepted bytes is
// compared against frames decoded from the serial line by a bit-sampling receiver.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CLK_FREQ = 160;
  localparam int UART_BPS = 10;
  localparam int BIT_CLKS = CLK_FREQ / UART_BPS;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CLKS = BIT_CLKS * NBITS;
  localparam int TMO        = 2000;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] pi_data = 8'h00;
  logic       pi_flag = 1'b0;
  logic       tx_ready, tx_busy, tx;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  uart_tx #(.UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .pi_data (pi_data),
    .pi_flag (pi_flag),
    .tx_ready(tx_ready),
    .tx_busy (tx_busy),
    .tx      (tx)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Offer a byte until it is accepted; the accepted byte joins the model queue.
  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    int n = 0;
    acc_cyc = cyc;
    @(negedge sys_clk);
    pi_data = b;
    pi_flag = 1'b1;
    while (!tx_ready && n < TMO) begin
      @(negedge sys_clk);
      n++;
    end
    if (!tx_ready) begin
      check("send_ready_timeout", 32'(tx_ready), 1);
      pi_flag = 1'b0;
      return;
    end
    @(posedge sys_clk);
    #1;
    acc_cyc = cyc;
    exp_q.push_back(b);
    pi_flag = 1'b0;
  endtask

  // Decode one frame; each bit must hold its level for exactly BIT_CLKS samples.
  task automatic recv_frame(input string tag, output logic [7:0] data, output int start_cyc);
    logic [15:0] smp;
    logic [10:0] bits;
    int n = 0;
    data = '0;
    bits = '0;
    smp = '0;
    start_cyc = cyc;
    @(negedge sys_clk);
    while (tx !== 1'b0 && n < TMO) begin
      @(negedge sys_clk);
      n++;
    end
    if (tx !== 1'b0) begin
      check({tag, "_start_timeout"}, 32'(tx), 0);
      return;
    end
    start_cyc = cyc;
    for (int b = 0; b < NBITS; b++) begin
      for (int s = 0; s < BIT_CLKS; s++) begin
        if (b != 0 || s != 0) @(negedge sys_clk);
        smp[s] = tx;
      end
      bits[b] = smp[0];
      check({tag, "_bit_width"}, 32'(smp), 32'({16{smp[0]}}));
    end
    data = bits[8:1];
    check({tag, "_stop"}, 32'(bits[NBITS-1]), 1);
`ifdef UART_TX_PARITY_EN
    check({tag, "_parity"}, 32'(bits[9]), 32'(^data));
`endif
  endtask

  task automatic recv_check(input string tag, output int start_cyc);
    logic [7:0] d;
    int n;
    recv_frame(tag, d, start_cyc);
    n = exp_q.size();
    if (n == 0) check({tag, "_queue"}, 32'(n), 1);
    else check({tag, "_data"}, 32'(d), 32'(exp_q.pop_front()));
  endtask

  int a1, a2, s1, s2, lows, cnt_nz, acc;

  initial begin
    repeat (3) @(negedge sys_clk);
    check("rst_tx", 32'(tx), 1);
    check("rst_ready", 32'(tx_ready), 1);
    check("rst_busy", 32'(tx_busy), 0);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // 0x55 from idle: start bit two clocks after pi_flag, busy falls after stop
    fork
      send_byte(8'h55, a1);
      recv_check("t1", s1);
    join
    check("t1_latency", 32'(s1 - a1), 1);
    @(negedge sys_clk);
    check("t1_busy_after", 32'(tx_busy), 0);
    check("t1_ready_after", 32'(tx_ready), 1);

    // back-to-back: second byte waits on tx_ready, no idle gap between frames
    fork
      begin
        send_byte(8'hA3, a1);
        send_byte(8'h0F, a2);
      end
      begin
        recv_check("t2a", s1);
        recv_check("t2b", s2);
      end
    join
    check("t2_gap", 32'(s2 - s1), 32'(FRAME_CLKS));
    check("t2_accept_delay", 32'(a2 - a1), 2);

    // pi_flag held high with changing data: only accept-edge bytes are sent
    fork
      begin
        acc = 0;
        for (int c = 0; c < 4 * TMO && acc < 4; c++) begin
          @(negedge sys_clk);
          pi_flag = 1'b1;
          pi_data = 8'($urandom);
          if (tx_ready) begin
            exp_q.push_back(pi_data);
            acc++;
          end
        end
        @(posedge sys_clk);
        #1;
        pi_flag = 1'b0;
      end
      for (int k = 0; k < 4; k++) recv_check("t3", s1);
    join
    repeat (2) @(negedge sys_clk);
    check("t3_queue_empty", 32'(exp_q.size()), 0);
    check("t3_idle_busy", 32'(tx_busy), 0);

    // random bytes with random gaps
    fork
      for (int i = 0; i < 6; i++) begin
        repeat ($urandom_range(0, 40)) @(negedge sys_clk);
        send_byte(8'($urandom), a1);
      end
      for (int i = 0; i < 6; i++) recv_check("t4", s1);
    join

    // parity-relevant bytes, frame length
    fork
      begin
        send_byte(8'h07, a1);
        send_byte(8'h03, a2);
      end
      begin
        recv_check("t5a", s1);
        recv_check("t5b", s2);
      end
    join
    check("t5_frame_len", 32'(s2 - s1), 32'(FRAME_CLKS));
    repeat (2) @(negedge sys_clk);

    // reset during data bit 4 of 0xFF with 0x00 held: frame and held byte dropped
    send_byte(8'hFF, a1);
    send_byte(8'h00, a2);
    while (cyc < a1 + 1 + 5 * BIT_CLKS + BIT_CLKS / 2) @(negedge sys_clk);
    check("t6_held_pre", 32'(tx_ready), 0);
    sys_rst = 1'b1;
    #1;
    check("t6_rst_tx", 32'(tx), 1);
    check("t6_rst_ready", 32'(tx_ready), 1);
    check("t6_rst_busy", 32'(tx_busy), 0);
    exp_q.delete();
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    check("t6_post_idle", 32'(lows), 0);

    // idle: line high, baud counter parked at 0
    lows = 0;
    cnt_nz = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge sys_clk);
      if (tx !== 1'b1) lows++;
      if (dut.baud_cnt_q !== 16'd0) cnt_nz++;
    end
    check("t7_idle_tx", 32'(lows), 0);
    check("t7_idle_cnt", 32'(cnt_nz), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
